pattern_scan_ctrl: RTL and testbench
====================================

# pattern_scan_ctrl

Frame-level controller that feeds a serial "10101" pattern detector from a parallel word stream. It accepts words over a valid/ready handshake and shifts each word MSB-first into an overlapping Mealy detector. It counts detections across the whole frame, so matches spanning word boundaries are included. It raises a sticky threshold interrupt and signals frame completion; it sits between the word-oriented data path and the bit-serial detector.

## Interface
- WORD_W, 8, bits per input word (≥2)
- CNT_W, 8, width of match counter and threshold
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  begin a frame; honoured only in IDLE
- irq_threshold  in  CNT_W  match count that sets irq; sampled on accepted start; 0 disables irq
- in_valid  in  1  word available
- in_data  in  WORD_W  word, bit WORD_W-1 scanned first
- in_last  in  1  qualifies in_data as the frame's final word
- in_ready  out  1  controller can take a word
- busy  out  1  high in every state except IDLE
- match_pulse  out  1  one-cycle detector hit
- match_count  out  CNT_W  frame match count, saturating
- irq  out  1  sticky, count ≥ threshold
- done  out  1  one-cycle frame-complete pulse

## Operation
- Reset values: state IDLE, in_ready=0, busy=0, match_pulse=0, match_count=0, irq=0, done=0, detector in its idle state.
- States:
  - IDLE: start → ACCEPT. On entry to ACCEPT: clear match_count, clear irq, latch threshold, clear detector.
  - ACCEPT: in_ready=1. On in_valid&in_ready, latch in_data into the shift register and in_last into a flag → SHIFT.
  - SHIFT: present shift-register MSB to the detector with enable=1, shift left, decrement the bit counter. After the WORD_W-th bit: flag set → DRAIN, else → ACCEPT.
  - DRAIN: one cycle, absorbs the registered detection from the final bit → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Detector state persists across words within a frame and is cleared only at frame start and on reset.
- Detector function: overlapping "10101", registered Mealy output. The hit is asserted the cycle after the completing bit is presented while enable=1; hit=0 when enable=0.
- match_pulse equals the detector hit. On each hit, match_count increments and saturates at 2^CNT_W−1.
- irq is set in the same cycle match_count updates to a value ≥ threshold, provided threshold≠0. It holds until the next accepted start or reset.
- Boundary cases:
  - start outside IDLE is ignored; this includes start in DONE.
  - in_valid outside ACCEPT: no capture; data must be held by the source.
  - start and in_valid in the same IDLE cycle: only start acts.
  - Reset mid-frame returns all state to reset values immediately; the partial frame is discarded.

## Timing
- Handshake in cycle t: bit i (i=0 is MSB) is presented during cycle t+1+i. The corresponding match_pulse is in cycle t+2+i.
- Word throughput: one word per WORD_W+1 cycles.
- Last word: DRAIN in cycle t+WORD_W+1, DONE (done=1) in cycle t+WORD_W+2. match_count is final in the DONE cycle.
- start accepted in cycle s → in_ready=1 from cycle s+1.

## Structure
- Shared package holds:
  - state enum (IDLE, ACCEPT, SHIFT, DRAIN, DONE)
  - detector state encoding (D0–D4)
  - pattern constant 5'b10101
- Sub-module bit_pattern_detector: inputs clk, reset, en, clr, din; output hit. It is the five-state overlapping detector with synchronous clr, and en gates both state advance and hit.
- The controller contains the FSM, shift register, bit counter ($clog2(WORD_W+1) bits), saturating counter and irq logic.

## Test plan
- start, threshold=0, single word 0x15 with last → match_count=1, irq=0, done 10 cycles after the handshake.
- Single word 0xAA with last → two overlapping matches, match_pulse at bits 4 and 6, match_count=2.
- Words 0x01 then 0x50 (last) → exactly one match, spanning the word boundary; match_count=1.
- Three words 0xAA (last on the third), threshold=10 → match_count=10, irq set with the 10th pulse and still high after done.
- CNT_W=4, five words 0xAA → 18 hits, match_count saturates at 15.
- in_valid held high during SHIFT → no extra capture. start pulsed mid-frame → ignored. reset asserted during SHIFT → all outputs 0 and IDLE; a following frame of 0x15 gives match_count=1.

Source files
------------

// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared types and constants for the word-to-bit pattern scan controller
// and its serial "10101" detector.
package pattern_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    SHIFT,
    DRAIN,
    DONE
  } state_e;

  // Dk means the last k bits seen equal the first k bits of PATTERN.
  typedef enum logic [2:0] {
    D0,
    D1,
    D2,
    D3,
    D4
  } det_state_e;

  localparam logic [4:0] PATTERN = 5'b10101;

endpackage

// File: rtl/pattern_scan_ctrl_bit_pattern_detector.sv
// Overlapping "10101" Mealy detector with a registered hit; en gates both
// state advance and hit, clr synchronously returns to the empty state.
module bit_pattern_detector
  import pattern_scan_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic hit
);

  det_state_e state_q, state_d;
  logic       hit_q, hit_d;

  // NOTE: every signal gets a default at the top of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    if (clr) begin
      state_d = D0;
    end else if (en) begin
      hit_d = (state_q == D4) && (din == PATTERN[0]);
      case (state_q)
        D0:      state_d = din ? D1 : D0;
        D1:      state_d = din ? D1 : D2;
        D2:      state_d = din ? D3 : D0;
        D3:      state_d = din ? D1 : D4;
        // A completed match keeps its "101" tail as the start of the next one.
        D4:      state_d = din ? D3 : D0;
        default: state_d = D0;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= D0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Frame controller: accepts words over valid/ready, shifts them MSB-first
// into the detector, counts matches across the frame and raises irq/done.
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  irq_threshold,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              irq,
  output logic              done
);

  localparam int              BC_W    = $clog2(WORD_W + 1);
  localparam logic [BC_W-1:0] BC_LOAD = BC_W'(WORD_W);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;
  logic [BC_W-1:0]    bcnt_q, bcnt_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   thr_q, thr_d;
  logic               irq_q, irq_d;

  logic start_acc, take, det_en, det_hit;

  assign start_acc = (state_q == IDLE) && start;
  assign take      = (state_q == ACCEPT) && in_valid;
  assign det_en    = (state_q == SHIFT);

  bit_pattern_detector u_det (
    .clk   (clk),
    .reset (reset),
    .en    (det_en),
    .clr   (start_acc),
    .din   (sreg_q[WORD_W-1]),
    .hit   (det_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCEPT;
      ACCEPT:  if (in_valid) state_d = SHIFT;
      SHIFT:   if (bcnt_q == BC_W'(1)) state_d = last_q ? DRAIN : ACCEPT;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ACCEPT);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

  // NOTE: blocking assignments in combinational logic let later lines build on count_d within the same evaluation.
  always_comb begin
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    count_d = count_q;
    thr_d   = thr_q;
    irq_d   = irq_q;
    if (take) begin
      sreg_d = in_data;
      last_d = in_last;
      bcnt_d = BC_LOAD;
    end else if (det_en) begin
      sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
      bcnt_d = bcnt_q - 1'b1;
    end
    if (start_acc) begin
      count_d = '0;
      irq_d   = 1'b0;
      thr_d   = irq_threshold;
    end else if (det_hit) begin
      if (count_q != '1) count_d = count_q + 1'b1;
      irq_d = irq_q | ((thr_q != '0) && (count_d >= thr_q));
    end
  end

  // NOTE: the datapath flops are few and cheap, so all of them reset to make a mid-frame reset leave no residue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q  <= '0;
      bcnt_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      thr_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      last_q  <= last_d;
      count_q <= count_d;
      thr_q   <= thr_d;
      irq_q   <= irq_d;
    end
  end

  assign match_pulse = det_hit;
  assign match_count = count_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: an 8-bit-counter instance and a
// 4-bit-counter instance run in lockstep against a sliding-window reference.
module tb_pattern_scan_ctrl;

  localparam int W = 8;

  typedef logic [4:0][7:0] words_t;

  typedef struct packed {
    words_t     w;
    logic [2:0] n;
    logic [7:0] thr;
    logic [7:0] exp_cnt;
    logic [3:0] exp_cnt4;
    logic       exp_irq;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_data = '0;
  logic [7:0] irq_threshold = '0;
  logic [3:0] irq_threshold4 = '0;

  logic       in_ready, busy, match_pulse, irq, done;
  logic [7:0] match_count;
  logic       in_ready4, busy4, match_pulse4, irq4, done4;
  logic [3:0] match_count4;

  pattern_scan_ctrl #(.WORD_W(W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .irq_threshold(irq_threshold),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .busy(busy), .match_pulse(match_pulse),
    .match_count(match_count), .irq(irq), .done(done)
  );

  pattern_scan_ctrl #(.WORD_W(W), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .irq_threshold(irq_threshold4),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready4), .busy(busy4), .match_pulse(match_pulse4),
    .match_count(match_count4), .irq(irq4), .done(done4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Monitor: records the cycle of every pulse and the latest irq rise.
  int   pulse_q[$];
  int   pulse4_q[$];
  int   irq_rise = -1;
  int   irq4_rise = -1;
  logic irq_prev = 1'b0;
  logic irq4_prev = 1'b0;
  always @(negedge clk) begin
    if (match_pulse)  pulse_q.push_back(cyc);
    if (match_pulse4) pulse4_q.push_back(cyc);
    if (irq && !irq_prev)   irq_rise  <= cyc;
    if (irq4 && !irq4_prev) irq4_rise <= cyc;
    irq_prev  <= irq;
    irq4_prev <= irq4;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic words_t mk(input logic [7:0] a, b, c, d, e);
    words_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
    return r;
  endfunction

  // Reference: scan the frame's bit string with a 5-bit sliding window; a
  // match completing at bit i of a word handshaken in cycle h pulses at h+2+i.
  int exp_q[$];
  function automatic void model(input words_t w, input int n, input int hs[5]);
    logic [4:0] win;
    int         seen;
    win  = '0;
    seen = 0;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < W; i++) begin
        win = {win[3:0], w[k][W-1-i]};
        seen++;
        if (seen >= 5 && win == 5'b10101) exp_q.push_back(hs[k] + 2 + i);
      end
    end
  endfunction

  // Called just after a negedge; returns just after the negedge following capture.
  task automatic send_word(input logic [7:0] d, input logic last, output int hs);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    hs = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic run_frame(input words_t w, input int n, input logic [7:0] t,
                           input int exp_cnt, input int exp_cnt4,
                           input logic exp_irq, input logic exp_irq4);
    int s, done_c, p0, p40, np;
    int hs[5];
    logic [3:0] t4;
    t4  = t[3:0];
    hs  = '{default: 0};
    p0  = pulse_q.size();
    p40 = pulse4_q.size();
    start          = 1'b1;
    irq_threshold  = t;
    irq_threshold4 = t4;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", in_ready, 1);
    for (int k = 0; k < n; k++) send_word(w[k], k == n - 1, hs[k]);
    wait_done();
    done_c = cyc;
    check("done_latency", done_c - hs[n-1], W + 2);
    check("done4", done4, 1);
    check("count_at_done", match_count, exp_cnt);
    check("count4_at_done", match_count4, exp_cnt4);
    check("irq_at_done", irq, exp_irq);
    check("irq4_at_done", irq4, exp_irq4);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("irq_holds", irq, exp_irq);
    model(w, n, hs);
    check("pulse_count", pulse_q.size() - p0, exp_q.size());
    check("pulse4_count", pulse4_q.size() - p40, exp_q.size());
    np = (pulse_q.size() - p0 < exp_q.size()) ? pulse_q.size() - p0 : exp_q.size();
    for (int i = 0; i < np; i++) check("pulse_cycle", pulse_q[p0+i], exp_q[i]);
    if (exp_irq && exp_q.size() >= int'(t)) check("irq_rise", irq_rise, exp_q[t-1] + 1);
    else if (!exp_irq) check("irq_no_rise", irq_rise < s, 1);
    if (exp_irq4 && exp_q.size() >= int'(t4)) check("irq4_rise", irq4_rise, exp_q[t4-1] + 1);
  endtask

  vec_t vecs[8];

  initial begin
    int     hs_tmp, s, p0, total, n;
    int     hs0[5];
    words_t w;
    logic [7:0] t;
    logic [3:0] t4;

    vecs[0] = '{w: mk(8'h15, 0, 0, 0, 0),                     n: 1, thr: 0,  exp_cnt: 1,  exp_cnt4: 1,  exp_irq: 0};
    vecs[1] = '{w: mk(8'hAA, 0, 0, 0, 0),                     n: 1, thr: 0,  exp_cnt: 2,  exp_cnt4: 2,  exp_irq: 0};
    vecs[2] = '{w: mk(8'h01, 8'h50, 0, 0, 0),                 n: 2, thr: 0,  exp_cnt: 1,  exp_cnt4: 1,  exp_irq: 0};
    vecs[3] = '{w: mk(8'hAA, 8'hAA, 8'hAA, 0, 0),             n: 3, thr: 10, exp_cnt: 10, exp_cnt4: 10, exp_irq: 1};
    vecs[4] = '{w: mk(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA),     n: 5, thr: 0,  exp_cnt: 18, exp_cnt4: 15, exp_irq: 0};
    vecs[5] = '{w: mk(8'hAA, 0, 0, 0, 0),                     n: 1, thr: 3,  exp_cnt: 2,  exp_cnt4: 2,  exp_irq: 0};
    vecs[6] = '{w: mk(8'h15, 0, 0, 0, 0),                     n: 1, thr: 1,  exp_cnt: 1,  exp_cnt4: 1,  exp_irq: 1};
    vecs[7] = '{w: mk(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA),     n: 5, thr: 16, exp_cnt: 18, exp_cnt4: 15, exp_irq: 1};
    hs0 = '{default: 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_match_pulse", match_pulse, 0);
    check("rst_match_count", match_count, 0);
    check("rst_irq", irq, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven frames; irq4 follows from the low threshold nibble.
    for (int v = 0; v < 8; v++) begin
      t4 = vecs[v].thr[3:0];
      run_frame(vecs[v].w, int'(vecs[v].n), vecs[v].thr, int'(vecs[v].exp_cnt),
                int'(vecs[v].exp_cnt4), vecs[v].exp_irq,
                (t4 != 0) && (int'(vecs[v].exp_cnt) >= int'(t4)));
      if (v == 3 || v == 7) begin
        @(negedge clk);
        check("irq_sticky_after_done", irq, 1);
      end
    end

    // Randomized frames against the reference model
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 4);
      w = '0;
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0:       w[k] = 8'hAA;
          1:       w[k] = 8'h55;
          default: w[k] = 8'($urandom);
        endcase
      end
      t  = 8'($urandom_range(0, 12));
      t4 = t[3:0];
      model(w, n, hs0);
      total = exp_q.size();
      run_frame(w, n, t, (total > 255) ? 255 : total, (total > 15) ? 15 : total,
                (t != 0) && (total >= int'(t)), (t4 != 0) && (total >= int'(t4)));
    end

    // in_valid held throughout, start with valid in IDLE, start mid-frame and in DONE
    p0 = pulse_q.size();
    in_valid = 1'b1; in_data = 8'h15; in_last = 1'b1;
    irq_threshold = 0; irq_threshold4 = 0;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    check("held_ready_s1", in_ready, 1);
    @(negedge clk);
    check("held_no_ready_in_shift", in_ready, 0);
    check("held_busy_in_shift", busy, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("held_done_latency", cyc - s, W + 3);
    check("held_count", match_count, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", busy, 0);
    check("valid_in_idle_no_ready", in_ready, 0);
    @(negedge clk);
    check("still_idle", busy, 0);
    check("held_single_pulse", pulse_q.size() - p0, 1);
    in_valid = 1'b0; in_last = 1'b0;

    // Reset during SHIFT after matches and irq have built up
    start = 1'b1; irq_threshold = 1; irq_threshold4 = 1;
    @(negedge clk);
    start = 1'b0;
    send_word(8'hAA, 1'b0, hs_tmp);
    send_word(8'hAA, 1'b0, hs_tmp);
    repeat (3) @(negedge clk);
    check("pre_reset_irq", irq, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_match_pulse", match_pulse, 0);
    check("mid_rst_match_count", match_count, 0);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_count4", match_count4, 0);
    @(negedge clk);
    check("mid_rst_idle", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    run_frame(mk(8'h15, 0, 0, 0, 0), 1, 8'd0, 1, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
